bcd_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter, the next generation of our two-digit 0-99 counter. It counts in packed BCD with per-digit carry and borrow, and supports parallel load, direction control, and wrap or saturate at the range limits. It raises a terminal-count strobe and a sticky overflow flag. It drives 7-segment display muxes and event tallies directly, and its terminal-count output can cascade into another instance's `en`.

---
 rtl/bcd_counter_n.sv | 92 +++++++++
 tb/tb_bcd_counter_n.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised N-digit packed-BCD up/down counter with
// parallel load (clamped per digit), wrap or saturate at the range limits,
// a combinational terminal-count strobe and a sticky overflow flag.
module bcd_counter_n #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ovf
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] step_val;
    logic [W-1:0] clamp_val;
    logic         ovf_q, ovf_d;
    logic         all9, all0;
    logic         carry;
    logic [3:0]   dig;
    logic [3:0]   ld_dig;

    // Ripple a one-digit step through the count and clamp the load value per digit
    always_comb begin
        step_val  = cnt_q;
        clamp_val = '0;
        all9      = 1'b1;
        all0      = 1'b1;
        carry     = 1'b1;
        dig       = '0;
        ld_dig    = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            dig = cnt_q[4*k +: 4];
            if (dig != 4'd9) all9 = 1'b0;
            if (dig != 4'd0) all0 = 1'b0;
            // carry stays set only while every lower digit sat at its limit
            if (carry) begin
                if (up) begin
                    step_val[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                    carry              = (dig == 4'd9);
                end else begin
                    step_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                    carry              = (dig == 4'd0);
                end
            end
            ld_dig             = load_val[4*k +: 4];
            clamp_val[4*k +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
        end
    end

    // Terminal count: an enabled step that is about to cross a range limit
    assign tc = en && !load && !rst && (up ? all9 : all0);

    // Next count and overflow: load beats count; at a limit wrap or hold
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (load) begin
            cnt_d = clamp_val;
            ovf_d = 1'b0;
        end else if (en) begin
            if (tc) begin
                ovf_d = 1'b1;
                if (WRAP) cnt_d = step_val;
            end else begin
                cnt_d = step_val;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed checks of bcd_counter_n in several
// configurations plus a randomized run against an integer reference model
// and a two-instance cascade compared with a single two-digit counter.
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;

    logic [7:0]  qa, qc;
    logic [15:0] qb;
    logic [3:0]  q_lo, q_hi;
    logic        tc_a, tc_b, tc_c, tc_lo, tc_hi;
    logic        ovf_a, ovf_b, ovf_c, ovf_lo, ovf_hi;

    int checks = 0;
    int errors = 0;

    // reference model state (plain integers)
    int ma = 0, mb = 0, mc = 0;
    bit moa = 1'b0, mob = 1'b0, moc = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[7:0]), .q(qa), .tc(tc_a), .ovf(ovf_a));

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(qb), .tc(tc_b), .ovf(ovf_b));

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[7:0]), .q(qc), .tc(tc_c), .ovf(ovf_c));

    bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_lo (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .q(q_lo), .tc(tc_lo), .ovf(ovf_lo));

    bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .up(up), .load(load),
        .load_val(load_val[7:4]), .q(q_hi), .tc(tc_hi), .ovf(ovf_hi));

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_load(input logic [15:0] lv, input int digits);
        int v = 0;
        int d;
        for (int k = 0; k < digits; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int digits);
        logic [15:0] r = '0;
        int x = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic mstep(input int digits, input bit wrap, inout int v, inout bit o);
        int mx = pow10(digits) - 1;
        if (rst) begin
            v = 0; o = 1'b0;
        end else if (load) begin
            v = clamp_load(load_val, digits); o = 1'b0;
        end else if (en) begin
            if (up) begin
                if (v == mx) begin o = 1'b1; v = wrap ? 0 : mx; end
                else v = v + 1;
            end else begin
                if (v == 0) begin o = 1'b1; v = wrap ? mx : 0; end
                else v = v - 1;
            end
        end
    endtask

    always @(posedge clk) begin
        mstep(2, 1'b1, ma, moa);
        mstep(4, 1'b1, mb, mob);
        mstep(2, 1'b0, mc, moc);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        tick();
        checks++;
        if (qa !== 8'h00 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL reset_a: q=%h ovf=%b, want 00/0", qa, ovf_a);
        end
        checks++;
        if (qb !== 16'h0000 || qc !== 8'h00 || ovf_b !== 1'b0 || ovf_c !== 1'b0) begin
            errors++; $display("FAIL reset_bc: qb=%h qc=%h ovf_b=%b ovf_c=%b, want 0", qb, qc, ovf_b, ovf_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep;
        int n;
        int tc_count = 0;
        logic [7:0] exp;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++;
            if (tc_a !== (i == 99)) begin
                errors++; $display("FAIL sweep_tc[%0d]: tc=%b, want %b", i, tc_a, (i == 99));
            end
            if (tc_a === 1'b1) tc_count++;
            tick();
            n = (i + 1) % 100;
            exp = 8'((n / 10) * 16 + (n % 10));
            checks++;
            if (qa !== exp || ovf_a !== (i == 99)) begin
                errors++; $display("FAIL sweep_q[%0d]: q=%h ovf=%b, want %h/%b", i, qa, ovf_a, exp, (i == 99));
            end
        end
        checks++;
        if (tc_count != 1) begin
            errors++; $display("FAIL sweep_tc_count: got %0d, want 1", tc_count);
        end
        en = 1'b0;
    endtask

    task automatic test_down_borrow;
        load_val = 16'h1000; load = 1'b1; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if (qb !== 16'h0999 || ovf_b !== 1'b0) begin
            errors++; $display("FAIL borrow_q: q=%h ovf=%b, want 0999/0", qb, ovf_b);
        end
        en = 1'b0; load_val = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (tc_b !== 1'b1) begin
            errors++; $display("FAIL borrow_tc: tc=%b, want 1", tc_b);
        end
        tick();
        checks++;
        if (qb !== 16'h9999 || ovf_b !== 1'b1) begin
            errors++; $display("FAIL borrow_wrap: q=%h ovf=%b, want 9999/1", qb, ovf_b);
        end
        en = 1'b0;
    endtask

    task automatic test_saturate;
        load_val = 16'h0098; load = 1'b1; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (tc_c !== (i > 0)) begin
                errors++; $display("FAIL sat_tc[%0d]: tc=%b, want %b", i, tc_c, (i > 0));
            end
            tick();
            checks++;
            if (qc !== 8'h99 || ovf_c !== (i > 0)) begin
                errors++; $display("FAIL sat_q[%0d]: q=%h ovf=%b, want 99/%b", i, qc, ovf_c, (i > 0));
            end
        end
        up = 1'b0;
        #1;
        checks++;
        if (tc_c !== 1'b0) begin
            errors++; $display("FAIL sat_down_tc: tc=%b, want 0", tc_c);
        end
        tick();
        checks++;
        if (qc !== 8'h98 || ovf_c !== 1'b1) begin
            errors++; $display("FAIL sat_down: q=%h ovf=%b, want 98/1", qc, ovf_c);
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority;
        load_val = 16'h00AC; load = 1'b1; en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (tc_a !== 1'b0) begin
            errors++; $display("FAIL load_tc: tc=%b, want 0", tc_a);
        end
        tick();
        checks++;
        if (qa !== 8'h99 || qc !== 8'h99 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL load_clamp: qa=%h qc=%h ovf=%b, want 99/99/0", qa, qc, ovf_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tc_a !== 1'b0) begin
            errors++; $display("FAIL rst_tc: tc=%b, want 0", tc_a);
        end
        tick();
        checks++;
        if (qa !== 8'h00 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL rst_over_load: q=%h ovf=%b, want 00/0", qa, ovf_a);
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_enable_dir;
        logic [3:0]  en_pat;
        logic [31:0] exp_pat;
        en_pat  = 4'b0101;
        exp_pat = 32'h10100909;
        load_val = 16'h0008; load = 1'b1;
        tick();
        load = 1'b0; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en = en_pat[i];
            tick();
            checks++;
            if (qa !== exp_pat[8*i +: 8]) begin
                errors++; $display("FAIL gate[%0d]: q=%h, want %h", i, qa, exp_pat[8*i +: 8]);
            end
        end
        up = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (qa !== 8'h09) begin
            errors++; $display("FAIL dir_flip: q=%h, want 09", qa);
        end
        en = 1'b0;
    endtask

    task automatic test_random;
        int r;
        logic [15:0] ea, eb, ec;
        logic        ta, tb, tcx;
        for (int i = 0; i < 10000; i++) begin
            r        = int'($urandom_range(0, 99));
            rst      = (r == 0);
            load     = (r >= 1 && r <= 5);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 1) == 1);
            load_val = 16'($urandom);
            #1;
            ta  = en && !load && !rst && (up ? (ma == 99)   : (ma == 0));
            tb  = en && !load && !rst && (up ? (mb == 9999) : (mb == 0));
            tcx = en && !load && !rst && (up ? (mc == 99)   : (mc == 0));
            checks++;
            if (tc_a !== ta || tc_b !== tb || tc_c !== tcx) begin
                errors++; $display("FAIL rand_tc[%0d]: a=%b b=%b c=%b, want %b %b %b", i, tc_a, tc_b, tc_c, ta, tb, tcx);
            end
            tick();
            ea = to_bcd(ma, 2); eb = to_bcd(mb, 4); ec = to_bcd(mc, 2);
            checks++;
            if (qa !== ea[7:0] || ovf_a !== moa) begin
                errors++; $display("FAIL rand_a[%0d]: q=%h ovf=%b, want %h/%b", i, qa, ovf_a, ea[7:0], moa);
            end
            checks++;
            if (qb !== eb || ovf_b !== mob) begin
                errors++; $display("FAIL rand_b[%0d]: q=%h ovf=%b, want %h/%b", i, qb, ovf_b, eb, mob);
            end
            checks++;
            if (qc !== ec[7:0] || ovf_c !== moc) begin
                errors++; $display("FAIL rand_c[%0d]: q=%h ovf=%b, want %h/%b", i, qc, ovf_c, ec[7:0], moc);
            end
            checks++;
            if ({q_hi, q_lo} !== ea[7:0]) begin
                errors++; $display("FAIL cascade[%0d]: q=%h, want %h", i, {q_hi, q_lo}, ea[7:0]);
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_sweep();
        test_down_borrow();
        test_saturate();
        test_load_priority();
        test_enable_dir();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
